// File: rtl/instruction_fetch.sv
// instruction_fetch
//   Front end of the instruction parser. Holds the program counter, issues one
//   word read at a time to instruction memory over a req/ack handshake, and
//   queues returned words in a small FIFO that feeds the parser through a
//   valid/ready handshake. A jump flushes the FIFO and squashes any read that is
//   still in flight. Halt stops new reads but lets the FIFO drain.
//
// Ports
//   clock, reset        rising-edge clock, synchronous active-high reset
//   halt                level; blocks issue of new reads
//   jumpValid/Target    one-cycle redirect of the fetch stream
//   memReq/memAddress   read request and its word address (held until ack)
//   memAck/memData      read completion and returned word
//   instruction*        FIFO head word, its fetch address, and non-empty flag
//   instructionReady    parser accepts the head word
module instruction_fetch #(
  parameter int INSTRUCTION_WIDTH = 32,
  parameter int PC_WIDTH          = 8,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0,
  parameter int FIFO_DEPTH        = 2
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         halt,
  input  logic                         jumpValid,
  input  logic [PC_WIDTH-1:0]          jumpTarget,
  output logic                         memReq,
  output logic [PC_WIDTH-1:0]          memAddress,
  input  logic                         memAck,
  input  logic [INSTRUCTION_WIDTH-1:0] memData,
  output logic [INSTRUCTION_WIDTH-1:0] instruction,
  output logic [PC_WIDTH-1:0]          instructionPC,
  output logic                         instructionValid,
  input  logic                         instructionReady
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  typedef enum logic {IDLE, REQ} state_t;

  state_t                 state_q;
  logic                   memReq_q;
  logic [PC_WIDTH-1:0]    memAddress_q;
  logic [PC_WIDTH-1:0]    pc_q, pc_d;
  logic                   squash_q;
  logic [PTR_W-1:0]       wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]       count_q, count_d;

  logic [INSTRUCTION_WIDTH-1:0] fifo_instr_q [FIFO_DEPTH];
  logic [PC_WIDTH-1:0]          fifo_pc_q    [FIFO_DEPTH];

  logic complete, push, pop, issue;

  always_comb begin
    complete = (state_q == REQ) && memAck;
    // Squashed reads and reads finishing in a jump cycle are dropped.
    push     = complete && !squash_q && !jumpValid;
    // A pop in a jump cycle is irrelevant: the FIFO is flushed anyway.
    pop      = (count_q != '0) && instructionReady && !jumpValid;

    if (jumpValid)
      count_d = '0;
    else
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);

    if (jumpValid)
      pc_d = jumpTarget;
    else if (push)
      pc_d = memAddress_q + 1'b1;
    else
      pc_d = pc_q;

    // Issue only when the next read is guaranteed a FIFO slot on return.
    issue = !halt && !jumpValid && (count_d < CNT_W'(FIFO_DEPTH));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      memReq_q     <= 1'b0;
      memAddress_q <= RESET_PC;
      pc_q         <= RESET_PC;
      squash_q     <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      pc_q    <= pc_d;
      count_q <= count_d;

      if (jumpValid) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      end

      case (state_q)
        IDLE: begin
          if (issue) begin
            state_q      <= REQ;
            memReq_q     <= 1'b1;
            memAddress_q <= pc_d;
          end
        end
        REQ: begin
          if (complete) begin
            squash_q <= 1'b0;
            if (issue) begin
              memAddress_q <= pc_d;
            end else begin
              state_q  <= IDLE;
              memReq_q <= 1'b0;
            end
          end else if (jumpValid) begin
            // Keep the bus request stable; the late data is dropped on ack.
            squash_q <= 1'b1;
          end
        end
        default: begin
          state_q  <= IDLE;
          memReq_q <= 1'b0;
        end
      endcase
    end
  end

  // Storage is not reset; occupancy is tracked by count_q.
  always_ff @(posedge clock) begin
    if (push) begin
      fifo_instr_q[wr_ptr_q] <= memData;
      fifo_pc_q[wr_ptr_q]    <= memAddress_q;
    end
  end

  always_comb begin
    memReq           = memReq_q;
    memAddress       = memAddress_q;
    instructionValid = (count_q != '0);
    instruction      = instructionValid ? fifo_instr_q[rd_ptr_q] : '0;
    instructionPC    = instructionValid ? fifo_pc_q[rd_ptr_q]    : '0;
  end

endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;

  localparam int IW    = 32;
  localparam int PW    = 8;
  localparam int DEPTH = 2;

  logic          clock, reset, halt, jumpValid, memReq, memAck;
  logic          instructionValid, instructionReady;
  logic [PW-1:0] jumpTarget, memAddress, instructionPC;
  logic [IW-1:0] memData, instruction;

  instruction_fetch #(
    .INSTRUCTION_WIDTH(IW), .PC_WIDTH(PW), .RESET_PC('0), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clock(clock), .reset(reset), .halt(halt), .jumpValid(jumpValid),
    .jumpTarget(jumpTarget), .memReq(memReq), .memAddress(memAddress),
    .memAck(memAck), .memData(memData), .instruction(instruction),
    .instructionPC(instructionPC), .instructionValid(instructionValid),
    .instructionReady(instructionReady)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int checks = 0;
  int errors = 0;

  // Behavioural reference: a queue of fetched words plus the single
  // outstanding read (if any) and the next fetch address.
  typedef struct packed { logic [IW-1:0] d; logic [PW-1:0] pc; } ent_t;
  ent_t          mq[$];
  logic          m_busy, m_squash, started;
  logic [PW-1:0] m_addr, m_pc;

  logic [PW-1:0] got[$];
  int            ackcnt;
  logic          force_ack;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  task automatic compare_model();
    logic          mv;
    logic [IW-1:0] md;
    logic [PW-1:0] mp;
    mv = (mq.size() != 0);
    md = mv ? mq[0].d  : '0;
    mp = mv ? mq[0].pc : '0;
    chk("memReq",           memReq,           m_busy);
    chk("memAddress",       memAddress,       m_addr);
    chk("instructionValid", instructionValid, mv);
    chk("instruction",      instruction,      md);
    chk("instructionPC",    instructionPC,    mp);
  endtask

  task automatic model_update();
    logic done, popped;
    if (reset) begin
      mq.delete();
      m_busy = 0; m_squash = 0; m_addr = '0; m_pc = '0;
      started = 1;
      return;
    end
    done   = m_busy && memAck;
    popped = (mq.size() != 0) && instructionReady;
    if (done) m_squash = 0;
    if (jumpValid) begin
      mq.delete();
      m_pc = jumpTarget;
      if (m_busy && !done) m_squash = 1;
    end else begin
      if (popped) void'(mq.pop_front());
      if (done && !m_squash_prev) begin
        mq.push_back('{d: memData, pc: m_addr});
        m_pc = m_addr + 1'b1;
      end
    end
    if (!m_busy || done) begin
      if (!halt && !jumpValid && mq.size() < DEPTH) begin
        m_busy = 1;
        m_addr = m_pc;
      end else begin
        m_busy = 0;
      end
    end
  endtask

  logic m_squash_prev;

  // One clock cycle: check at the falling edge, drive inputs, then advance
  // the model on the rising edge with the same inputs the DUT samples.
  task automatic step(input logic r, input logic h, input logic j,
                      input logic [PW-1:0] jt, input logic a, input logic rd);
    if (started) compare_model();
    if (started && !r && !j && rd && instructionValid) got.push_back(instructionPC);
    reset            = r;
    halt             = h;
    jumpValid        = j;
    jumpTarget       = jt;
    memAck           = a && (memReq || force_ack);
    memData          = $urandom;
    instructionReady = rd;
    if (memAck) ackcnt++;
    @(posedge clock);
    m_squash_prev = m_squash;
    model_update();
    @(negedge clock);
  endtask

  task automatic do_reset();
    step(1, 0, 0, '0, 0, 0);
    step(1, 0, 0, '0, 0, 0);
    got.delete();
    ackcnt = 0;
  endtask

  initial begin
    int n;
    started = 0; force_ack = 0; ackcnt = 0;
    m_busy = 0; m_squash = 0; m_squash_prev = 0; m_addr = '0; m_pc = '0;
    reset = 1; halt = 0; jumpValid = 0; jumpTarget = '0;
    memAck = 0; memData = '0; instructionReady = 0;
    @(negedge clock);

    // Reset state
    do_reset();
    chk("rst_memReq", memReq, 0);
    chk("rst_memAddress", memAddress, 0);
    chk("rst_valid", instructionValid, 0);
    chk("rst_instruction", instruction, 0);
    chk("rst_instructionPC", instructionPC, 0);

    // Streaming with same-cycle acks and ready held high
    step(0, 0, 0, '0, 1, 1);
    chk("lat_memReq", memReq, 1);
    chk("lat_addr", memAddress, 0);
    step(0, 0, 0, '0, 1, 1);
    chk("lat_valid", instructionValid, 1);
    chk("lat_pc", instructionPC, 0);
    for (int i = 0; i < 10; i++) step(0, 0, 0, '0, 1, 1);
    chk("stream_count", got.size() >= 8, 1);
    for (int i = 0; i < 8 && i < got.size(); i++) chk("stream_order", got[i], i);

    // Back-pressure fills the FIFO, then fetching resumes
    do_reset();
    for (int i = 0; i < 8; i++) step(0, 0, 0, '0, 1, 0);
    chk("bp_acks", ackcnt, DEPTH);
    chk("bp_memReq", memReq, 0);
    chk("bp_headpc", instructionPC, 0);
    step(0, 0, 0, '0, 1, 1);
    chk("bp_resume_req", memReq, 1);
    chk("bp_resume_addr", memAddress, 2);
    for (int i = 0; i < 4; i++) step(0, 0, 0, '0, 1, 1);
    chk("bp_got0", got[0], 0);
    chk("bp_got1", got[1], 1);
    chk("bp_got2", got[2], 2);

    // Jump while read to address 5 is pending
    do_reset();
    n = 0;
    while (!(memReq && memAddress == 5) && n < 50) begin
      step(0, 0, 0, '0, 1, 1);
      n++;
    end
    chk("j5_reached", n < 50, 1);
    step(0, 0, 0, '0, 0, 1);
    step(0, 0, 0, '0, 0, 1);
    got.delete();
    step(0, 0, 1, 8'h40, 0, 1);
    chk("j5_hold_req", memReq, 1);
    chk("j5_hold_addr", memAddress, 5);
    chk("j5_flushed", instructionValid, 0);
    step(0, 0, 0, '0, 1, 1);
    chk("j5_new_addr", memAddress, 8'h40);
    chk("j5_dropped", instructionValid, 0);
    step(0, 0, 0, '0, 1, 1);
    chk("j5_first_pc", instructionPC, 8'h40);
    chk("j5_first_valid", instructionValid, 1);

    // Jump in the same cycle as an ack, with a word already queued
    do_reset();
    step(0, 0, 0, '0, 0, 0);
    step(0, 0, 0, '0, 1, 0);
    step(0, 0, 0, '0, 0, 0);
    chk("ja_queued", instructionValid, 1);
    step(0, 0, 1, 8'h80, 1, 0);
    chk("ja_empty", instructionValid, 0);
    chk("ja_idle", memReq, 0);
    step(0, 0, 0, '0, 0, 0);
    chk("ja_req", memReq, 1);
    chk("ja_addr", memAddress, 8'h80);
    step(0, 0, 0, '0, 1, 0);
    chk("ja_pc", instructionPC, 8'h80);

    // PC wrap and halt during a pending read
    do_reset();
    step(0, 0, 1, 8'hFF, 0, 0);
    step(0, 0, 0, '0, 0, 0);
    chk("wrap_addr_ff", memAddress, 8'hFF);
    step(0, 0, 0, '0, 1, 0);
    chk("wrap_addr_00", memAddress, 8'h00);
    step(0, 1, 0, '0, 0, 0);
    step(0, 1, 0, '0, 1, 0);
    chk("halt_stop", memReq, 0);
    chk("halt_pushed", instructionPC, 8'hFF);
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 0, '0, 1, 1);
      chk("halt_noreq", memReq, 0);
    end
    chk("halt_got0", got[0], 8'hFF);
    chk("halt_got1", got[1], 8'h00);

    // Reset in the middle of a transaction
    do_reset();
    step(0, 0, 0, '0, 0, 0);
    step(0, 0, 0, '0, 1, 0);
    chk("mr_busy", memReq, 1);
    step(1, 0, 0, '0, 1, 0);
    chk("mr_memReq", memReq, 0);
    chk("mr_addr", memAddress, 0);
    chk("mr_valid", instructionValid, 0);
    chk("mr_instr", instruction, 0);
    chk("mr_pc", instructionPC, 0);
    force_ack = 1;
    step(0, 0, 0, '0, 1, 0);
    force_ack = 0;
    chk("mr_late_ack", instructionValid, 0);
    chk("mr_reissue", memReq, 1);

    // Randomised traffic against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      logic [PW-1:0] jt;
      jt = PW'($urandom);
      step($urandom_range(0, 199) == 0, $urandom_range(0, 9) == 0,
           $urandom_range(0, 19) == 0, jt, $urandom_range(0, 1) == 1,
           $urandom_range(0, 9) < 7);
    end
    step(0, 0, 0, '0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
